// File: rtl/pipeline_debug_controller_pkg.sv
// Shared definitions for the pipeline debug controller: FSM states and dump geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_debug_controller_pkg;

  localparam int N_REGS         = 32;
  localparam int BYTES_PER_WORD = 4;
  // Registers 0..N_REGS-1 followed by one trailing cycle-count word.
  localparam int DUMP_WORDS     = N_REGS + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    STEP_WAIT,
    STEP_EXEC,
    DUMP_READ,
    DUMP_SEND,
    DONE
  } state_t;

endpackage

// File: rtl/pipeline_debug_controller_if.sv
// Debug-controller bundle: run control, halt detect, register read port, UART tx byte stream.
// Latency: n/a (wires only).
// Backpressure: tx side is valid/ready; o_tx_data holds while o_tx_valid && !i_tx_ready.
// Ports: slave = controller side (takes i_*, drives o_*); master = environment side.
interface pipeline_debug_controller_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
) ();

  logic               i_start;
  logic               i_mode_step;
  logic               i_step;
  logic               i_halt_detected;
  logic [NB_DATA-1:0] i_reg_data;
  logic               i_tx_ready;
  logic               o_pipeline_enable;
  logic               o_pipeline_reset;
  logic [NB_REG-1:0]  o_reg_addr;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic [NB_DATA-1:0] o_cycle_count;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_start, i_mode_step, i_step, i_halt_detected, i_reg_data, i_tx_ready,
    output o_pipeline_enable, o_pipeline_reset, o_reg_addr, o_tx_data, o_tx_valid,
           o_cycle_count, o_busy, o_done
  );

  modport master (
    output i_start, i_mode_step, i_step, i_halt_detected, i_reg_data, i_tx_ready,
    input  o_pipeline_enable, o_pipeline_reset, o_reg_addr, o_tx_data, o_tx_valid,
           o_cycle_count, o_busy, o_done
  );

endinterface

// File: rtl/pipeline_debug_controller_word_serializer.sv
// Splits one loaded word into bytes, least-significant first, on a valid/ready stream.
// Latency: first byte valid the cycle after i_load; one byte per accepted handshake.
// Backpressure: byte index and o_data hold while o_valid && !i_ready.
// Ports: i_load/i_word load a word; o_valid/o_data/i_ready byte stream; o_last marks the final byte.
module word_serializer
  import pipeline_debug_controller_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_BYTE-1:0] o_data,
  output logic               o_last
);

  localparam int NB_IDX = $clog2(BYTES_PER_WORD);

  logic [NB_DATA-1:0] word_buf;
  logic [NB_IDX-1:0]  byte_idx;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_buf <= '0;
      byte_idx <= '0;
      o_valid  <= 1'b0;
    end else if (i_load) begin
      word_buf <= i_word;
      byte_idx <= '0;
      o_valid  <= 1'b1;
    end else if (o_valid && i_ready) begin
      if (o_last) begin
        o_valid <= 1'b0;
      end else begin
        byte_idx <= byte_idx + NB_IDX'(1);
      end
    end
  end

  assign o_last = (byte_idx == NB_IDX'(BYTES_PER_WORD - 1));
  assign o_data = word_buf[NB_BYTE*int'(byte_idx) +: NB_BYTE];

endmodule

// File: rtl/pipeline_debug_controller.sv
// Runs the pipeline continuously or single-step until HALT, then dumps registers plus cycle count over UART.
// Latency: one CLEAR cycle before execution; each dump word takes one read cycle plus four byte handshakes.
// Backpressure: dump stalls on i_tx_ready low with o_tx_data held; no input reaches an output combinationally.
// Ports: i_clock/i_reset (sync, active-high); dbg carries run control, register read port and tx stream.
module pipeline_debug_controller
  import pipeline_debug_controller_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8,
  parameter int N_REGS  = pipeline_debug_controller_pkg::N_REGS
) (
  input logic                            i_clock,
  input logic                            i_reset,
  pipeline_debug_controller_if.slave     dbg
);

  localparam int NB_WIDX = $clog2(N_REGS + 1);

  state_t             state;
  state_t             next_state;
  logic               mode_step;
  logic [NB_WIDX-1:0] word_idx;
  logic [NB_DATA-1:0] cycle_count;

  logic               start_ok;
  logic               last_word;
  logic               last_accept;
  logic               ser_valid;
  logic               ser_last;
  logic [NB_DATA-1:0] load_word;

  logic               pipeline_enable;
  logic               pipeline_reset;
  logic               busy;
  logic               done;
  logic [NB_REG-1:0]  reg_addr;

  assign start_ok    = dbg.i_start && (state == IDLE || state == DONE);
  assign last_word   = (word_idx == NB_WIDX'(N_REGS));
  assign last_accept = ser_valid && dbg.i_tx_ready && ser_last;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (dbg.i_start)         next_state = CLEAR;
      CLEAR:                               next_state = mode_step ? STEP_WAIT : RUN;
      RUN:        if (dbg.i_halt_detected) next_state = DUMP_READ;
      STEP_WAIT:  if (dbg.i_step)          next_state = STEP_EXEC;
      STEP_EXEC:                           next_state = dbg.i_halt_detected ? DUMP_READ : STEP_WAIT;
      DUMP_READ:                           next_state = DUMP_SEND;
      DUMP_SEND:  if (last_accept)         next_state = last_word ? DONE : DUMP_READ;
      default:                             next_state = IDLE;
    endcase
  end

  // Outputs decoded from state (plus the registered word index)
  always_comb begin
    pipeline_enable = (state == RUN) || (state == STEP_EXEC);
    pipeline_reset  = (state == CLEAR);
    busy            = (state != IDLE) && (state != DONE);
    done            = (state == DONE);
    reg_addr        = '0;
    if (state == DUMP_READ || state == DUMP_SEND) reg_addr = NB_REG'(word_idx);
  end

  // Mode latch, cycle counter and dump word index. The count is zeroed on the
  // start edge so it already reads 0 during the CLEAR cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mode_step   <= 1'b0;
      word_idx    <= '0;
      cycle_count <= '0;
    end else begin
      if (start_ok) begin
        mode_step   <= dbg.i_mode_step;
        word_idx    <= '0;
        cycle_count <= '0;
      end
      if (pipeline_enable && cycle_count != '1) begin
        cycle_count <= cycle_count + NB_DATA'(1);
      end
      if (state == DUMP_SEND && last_accept && !last_word) begin
        word_idx <= word_idx + NB_WIDX'(1);
      end
    end
  end

  // The word after the last register is the final cycle count.
  assign load_word = last_word ? cycle_count : dbg.i_reg_data;

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (state == DUMP_READ),
    .i_word  (load_word),
    .i_ready (dbg.i_tx_ready),
    .o_valid (ser_valid),
    .o_data  (dbg.o_tx_data),
    .o_last  (ser_last)
  );

  assign dbg.o_pipeline_enable = pipeline_enable;
  assign dbg.o_pipeline_reset  = pipeline_reset;
  assign dbg.o_reg_addr        = reg_addr;
  assign dbg.o_tx_valid        = ser_valid;
  assign dbg.o_cycle_count     = cycle_count;
  assign dbg.o_busy            = busy;
  assign dbg.o_done            = done;

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Directed bench for pipeline_debug_controller: continuous, step, saturation, backpressure, reset mid-dump.
// Latency: n/a.
// Backpressure: bench drives i_tx_ready, stalling byte 0 of register 7 for five cycles.
module tb_pipeline_debug_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_debug_controller_if bus ();

  pipeline_debug_controller dut (
    .i_clock (clk),
    .i_reset (rst),
    .dbg     (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  int         en_cycles;
  int         en_pulses;
  logic       en_prev;

  // Register-bank contents seen through the debug read port.
  function automatic logic [31:0] reg_val(input logic [4:0] a);
    if (a == 5'd7) return 32'hA1B2_C3D4;
    return {3'b000, a, ~{3'b000, a}, 8'h5A, 8'h11 + {3'b000, a}};
  endfunction

  assign bus.i_reg_data = reg_val(bus.o_reg_addr);

  function automatic logic [7:0] exp_byte(input int idx, input logic [31:0] cnt);
    logic [31:0] w;
    w = (idx / 4 < 32) ? reg_val(5'(idx / 4)) : cnt;
    return w[8*(idx % 4) +: 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples the values the next rising edge will see, then returns 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (bus.o_tx_valid && bus.i_tx_ready) q.push_back(bus.o_tx_data);
      if (bus.o_pipeline_enable) begin
        en_cycles++;
        if (!en_prev) en_pulses++;
      end
      en_prev = bus.o_pipeline_enable;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic mode);
    bus.i_start     = 1'b1;
    bus.i_mode_step = mode;
    tick();
    bus.i_start     = 1'b0;
    bus.i_mode_step = 1'b0;
  endtask

  task automatic run_dump(input bit bp);
    int stall;
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.o_done) break;
      if (bp && q.size() == 28 && bus.o_tx_valid && stall < 5) begin
        bus.i_tx_ready = 1'b0;
        stall++;
        chk("bp_hold_data", bus.o_tx_data, 8'hD4);
        chk("bp_hold_valid", bus.o_tx_valid, 1'b1);
      end else begin
        bus.i_tx_ready = 1'b1;
      end
      tick();
    end
    chk("dump_done", bus.o_done, 1'b1);
    if (bp) chk("bp_stalls", stall, 5);
  endtask

  task automatic stream_check(input string tag, input logic [31:0] cnt);
    int mis;
    mis = 0;
    chk({tag, "_len"}, q.size(), 132);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] !== exp_byte(i, cnt)) mis++;
    end
    chk({tag, "_bytes"}, mis, 0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_en"},      bus.o_pipeline_enable, 1'b0);
    chk({p, "_preset"},  bus.o_pipeline_reset, 1'b0);
    chk({p, "_addr"},    bus.o_reg_addr, 5'd0);
    chk({p, "_txdata"},  bus.o_tx_data, 8'h00);
    chk({p, "_txvalid"}, bus.o_tx_valid, 1'b0);
    chk({p, "_count"},   bus.o_cycle_count, 32'd0);
    chk({p, "_busy"},    bus.o_busy, 1'b0);
    chk({p, "_done"},    bus.o_done, 1'b0);
  endtask

  task automatic clear_mon();
    q.delete();
    en_cycles = 0;
    en_pulses = 0;
    en_prev   = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.i_start         = 1'b0;
    bus.i_mode_step     = 1'b0;
    bus.i_step          = 1'b0;
    bus.i_halt_detected = 1'b0;
    bus.i_tx_ready      = 1'b1;
    clear_mon();
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.o_busy, 1'b0);

    // Continuous run, halt on the 10th RUN cycle, stall byte 0 of register 7.
    clear_mon();
    start(1'b0);
    chk("clr_preset", bus.o_pipeline_reset, 1'b1);
    chk("clr_en", bus.o_pipeline_enable, 1'b0);
    chk("clr_cnt", bus.o_cycle_count, 32'd0);
    chk("clr_busy", bus.o_busy, 1'b1);
    tick();
    for (int k = 1; k <= 10; k++) begin
      chk("run_en", bus.o_pipeline_enable, 1'b1);
      chk("run_preset", bus.o_pipeline_reset, 1'b0);
      chk("run_cnt", bus.o_cycle_count, 32'(k - 1));
      if (k == 5) begin
        bus.i_start = 1'b1;
        bus.i_step  = 1'b1;
      end
      if (k == 10) bus.i_halt_detected = 1'b1;
      tick();
      bus.i_start         = 1'b0;
      bus.i_step          = 1'b0;
      bus.i_halt_detected = 1'b0;
    end
    chk("halt_cnt", bus.o_cycle_count, 32'd10);
    chk("halt_en", bus.o_pipeline_enable, 1'b0);
    chk("cont_en_cycles", en_cycles, 10);
    chk("cont_en_pulses", en_pulses, 1);
    run_dump(1'b1);
    stream_check("cont", 32'd10);
    if (q.size() >= 32) begin
      chk("r7_b0", q[28], 8'hD4);
      chk("r7_b1", q[29], 8'hC3);
      chk("r7_b2", q[30], 8'hB2);
      chk("r7_b3", q[31], 8'hA1);
    end
    if (q.size() >= 129) chk("cnt_lsb", q[128], 8'h0A);
    chk("done_en", bus.o_pipeline_enable, 1'b0);
    chk("done_busy", bus.o_busy, 1'b0);
    chk("done_txv", bus.o_tx_valid, 1'b0);
    tick();
    chk("done_hold", bus.o_done, 1'b1);
    chk("done_cnt", bus.o_cycle_count, 32'd10);

    // Restart from DONE in step mode; halt on the 4th STEP_EXEC.
    clear_mon();
    start(1'b1);
    chk("rs_preset", bus.o_pipeline_reset, 1'b1);
    chk("rs_cnt", bus.o_cycle_count, 32'd0);
    chk("rs_done", bus.o_done, 1'b0);
    tick();
    chk("sw_en0", bus.o_pipeline_enable, 1'b0);
    tick();
    tick();
    chk("sw_cnt0", bus.o_cycle_count, 32'd0);
    for (int n = 1; n <= 3; n++) begin
      bus.i_step = 1'b1;
      tick();
      bus.i_step = 1'b0;
      chk("se_en", bus.o_pipeline_enable, 1'b1);
      tick();
      chk("sw_en", bus.o_pipeline_enable, 1'b0);
      chk("sw_cnt", bus.o_cycle_count, 32'(n));
      tick();
    end
    bus.i_step = 1'b1;
    tick();
    bus.i_step          = 1'b0;
    bus.i_halt_detected = 1'b1;
    chk("se4_en", bus.o_pipeline_enable, 1'b1);
    tick();
    bus.i_halt_detected = 1'b0;
    chk("step_cnt", bus.o_cycle_count, 32'd4);
    chk("step_en_cycles", en_cycles, 4);
    chk("step_en_pulses", en_pulses, 4);
    run_dump(1'b0);
    stream_check("step", 32'd4);

    // Saturation from a forced near-max count.
    clear_mon();
    start(1'b0);
    tick();
    force dut.cycle_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_count;
    @(posedge clk);
    #1;
    chk("sat1", bus.o_cycle_count, 32'hFFFF_FFFF);
    tick();
    chk("sat2", bus.o_cycle_count, 32'hFFFF_FFFF);
    bus.i_halt_detected = 1'b1;
    tick();
    bus.i_halt_detected = 1'b0;
    chk("sat3", bus.o_cycle_count, 32'hFFFF_FFFF);
    run_dump(1'b0);
    stream_check("sat", 32'hFFFF_FFFF);

    // Reset while byte 50 is on offer, then a full clean run.
    clear_mon();
    start(1'b0);
    tick();
    bus.i_halt_detected = 1'b1;
    tick();
    bus.i_halt_detected = 1'b0;
    bus.i_tx_ready      = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (q.size() >= 50) break;
      tick();
    end
    chk("pre_rst_len", q.size(), 50);
    chk("pre_rst_txv", bus.o_tx_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk_reset("mid");
    chk("abandon_len", q.size(), 50);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", bus.o_busy, 1'b0);
    clear_mon();
    start(1'b0);
    tick();
    tick();
    bus.i_halt_detected = 1'b1;
    tick();
    bus.i_halt_detected = 1'b0;
    chk("rerun_cnt", bus.o_cycle_count, 32'd2);
    run_dump(1'b0);
    stream_check("rerun", 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_debug_controller.md
PIPELINE_DEBUG_CONTROLLER -- requirements
Module: pipeline_debug_controller

Interface
REQ-001 SHALL have parameters: NB_DATA=32 (register/counter width); NB_REG=5 (register address width); NB_BYTE=8 (tx byte width); N_REGS=32 (registers dumped).
REQ-002 SHALL have ports, clock and reset first:
- i_clock  in  1  single clock, all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  pulse; begin a new program execution.
- i_mode_step  in  1  sampled with i_start; 1=step mode, 0=continuous.
- i_step  in  1  pulse; execute one cycle in step mode.
- i_halt_detected  in  1  HALT instruction has reached WB.
- i_reg_data  in  NB_DATA  combinational read data from registers-bank debug port.
- i_tx_ready  in  1  UART tx accepts a byte.
- o_pipeline_enable  out  1  enable for all stage registers.
- o_pipeline_reset  out  1  one-cycle flush of all stages.
- o_reg_addr  out  NB_REG  registers-bank debug read address.
- o_tx_data  out  NB_BYTE  byte to UART.
- o_tx_valid  out  1  o_tx_data valid.
- o_cycle_count  out  NB_DATA  enabled cycles since last start.
- o_busy  out  1  state not IDLE and not DONE.
- o_done  out  1  dump complete.

Function
REQ-003 SHALL implement states IDLE, CLEAR, RUN, STEP_WAIT, STEP_EXEC, DUMP_READ, DUMP_SEND, DONE.
REQ-004 IDLE/DONE: on i_start -> CLEAR, latching i_mode_step; otherwise hold; i_start ignored in all other states.
REQ-005 CLEAR: exactly one cycle, o_pipeline_reset=1, o_pipeline_enable=0, o_cycle_count cleared to 0; next RUN if latched mode=0, else STEP_WAIT.
REQ-006 RUN: o_pipeline_enable=1; o_cycle_count += 1 every RUN cycle; i_halt_detected=1 -> DUMP_READ next cycle (the halt cycle itself is counted).
REQ-007 STEP_WAIT: o_pipeline_enable=0; i_step=1 -> STEP_EXEC; i_step ignored in every other state.
REQ-008 STEP_EXEC: exactly one cycle, o_pipeline_enable=1, count += 1; i_halt_detected=1 in that cycle -> DUMP_READ, else -> STEP_WAIT.
REQ-009 o_cycle_count SHALL saturate at 2^NB_DATA-1, never wrap.
REQ-010 Dump sends words 0..N_REGS-1 (register i), then word N_REGS (o_cycle_count) = 33 words = 132 bytes, each word least-significant byte first.
REQ-011 DUMP_READ: o_reg_addr=word index; capture i_reg_data (or cycle count for word N_REGS) into a word buffer; one cycle; -> DUMP_SEND with byte index 0.
REQ-012 DUMP_SEND: o_tx_valid=1, o_tx_data=buffer byte[byte index]; o_tx_data stable while o_tx_valid=1 and i_tx_ready=0; byte advances only on o_tx_valid&i_tx_ready.
REQ-013 After byte 3 accepted: if word index < N_REGS -> increment word index, DUMP_READ; else -> DONE.
REQ-014 DONE: o_done=1, o_pipeline_enable=0, o_cycle_count held until next CLEAR.
REQ-015 o_pipeline_enable=0 and o_tx_valid=0 in every state not stated otherwise; o_reg_addr=0 outside DUMP states.
REQ-016 o_busy = not (IDLE or DONE); all outputs registered or decoded from state only (no input-to-output combinational path).

Reset
REQ-017 i_reset=1 at any edge, including mid-run or mid-handshake, SHALL force IDLE, o_cycle_count=0, word/byte indices=0, buffer=0, o_pipeline_reset=0, o_pipeline_enable=0, o_tx_valid=0, o_done=0, o_busy=0, o_reg_addr=0, o_tx_data=0.
REQ-018 A tx byte pending at reset SHALL be abandoned, not completed.

Structure
REQ-019 Shared package SHALL hold the state enumeration, N_REGS, BYTES_PER_WORD=4, and total dump word count (N_REGS+1).
REQ-020 One sub-module, word_serializer (NB_DATA word load, byte index, valid/ready output, last-byte flag), SHALL implement REQ-012; the FSM and counter stay in the top.

Verification
REQ-021 Continuous: start with mode=0, halt_detected at 10th RUN cycle -> o_cycle_count=10, 132 bytes sent, o_done=1.
REQ-022 Step: mode=1, three i_step pulses then halt on the 4th STEP_EXEC -> exactly 4 enable cycles of width 1, count=4.
REQ-023 Backpressure: i_tx_ready low 5 cycles on byte 0 of reg 7 (value 0xA1B2C3D4) -> 0xD4 held stable, bytes D4,C3,B2,A1 in order.
REQ-024 Saturation: preload count near max via long run (or forced value 0xFFFFFFFE), 3 more RUN cycles -> 0xFFFFFFFF.
REQ-025 Reset mid-dump at byte 50 -> next cycle IDLE, all outputs at reset values; subsequent start produces full 132-byte dump.
REQ-026 Restart from DONE: i_start -> one-cycle o_pipeline_reset, count=0; i_start/i_step during RUN ignored.
